// File: rtl/eu_ooo_issue_queue.sv
// Out-of-order issue queue: collapsing entry array (slot 0 = oldest) with
// tag-broadcast wakeup and oldest-ready select toward the EU's ALU.
module eu_ooo_issue_queue #(
    parameter int LOG2_DEPTH = 3,
    parameter int NUM_SRC    = 2,
    parameter int NUM_WAKE   = 2,
    parameter int OPCODE_W   = 6,
    parameter int TAG_W      = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      disp_valid_i,
    output logic                      disp_ready_o,
    input  logic [OPCODE_W-1:0]       disp_opcode_i,
    input  logic [TAG_W-1:0]          disp_dst_tag_i,
    input  logic [NUM_SRC*TAG_W-1:0]  disp_src_tag_i,
    input  logic [NUM_SRC-1:0]        disp_src_rdy_i,
    input  logic [NUM_WAKE-1:0]       wake_valid_i,
    input  logic [NUM_WAKE*TAG_W-1:0] wake_tag_i,
    output logic                      issue_valid_o,
    input  logic                      issue_ready_i,
    output logic [OPCODE_W-1:0]       issue_opcode_o,
    output logic [TAG_W-1:0]          issue_dst_tag_o,
    output logic [NUM_SRC*TAG_W-1:0]  issue_src_tag_o,
    input  logic                      flush_i,
    output logic [LOG2_DEPTH:0]       count_o
);

    localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;
    localparam int          CW    = LOG2_DEPTH + 1;

    logic [CW-1:0]                           r_count;
    logic [DEPTH-1:0]                        r_valid;
    logic [DEPTH-1:0][OPCODE_W-1:0]          r_op;
    logic [DEPTH-1:0][TAG_W-1:0]             r_dst;
    logic [DEPTH-1:0][NUM_SRC*TAG_W-1:0]     r_src;
    logic [DEPTH-1:0][NUM_SRC-1:0]           r_rdy;

    logic [DEPTH-1:0]                        w_vld_nxt;
    logic [DEPTH-1:0][OPCODE_W-1:0]          w_op_nxt;
    logic [DEPTH-1:0][TAG_W-1:0]             w_dst_nxt;
    logic [DEPTH-1:0][NUM_SRC*TAG_W-1:0]     w_src_nxt;
    logic [DEPTH-1:0][NUM_SRC-1:0]           w_rdy_nxt;
    logic [DEPTH-1:0][NUM_SRC-1:0]           w_rdy_wk;
    logic [NUM_SRC-1:0]                      w_disp_rdy;

    logic                  w_any;
    logic [LOG2_DEPTH-1:0] w_sel;
    logic                  w_issue_valid;
    logic                  w_issue_fire;
    logic                  w_disp_ready;
    logic                  w_disp_fire;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CW-1:0]         w_wr;

    function automatic logic f_match(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_WAKE-1:0]       wv,
        input logic [NUM_WAKE*TAG_W-1:0] wt
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned w = 0; w < NUM_WAKE; w++) begin
            if (wv[w] && (wt[w*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Readiness uses registered rdy bits only; wakeups become visible next cycle.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!w_any && r_valid[i] && (&r_rdy[i])) begin
                w_any = 1'b1;
                w_sel = LOG2_DEPTH'(i);
            end
        end
    end

    assign w_issue_valid = w_any & ~flush_i & ~reset;
    assign w_issue_fire  = w_issue_valid & issue_ready_i;
    assign w_disp_ready  = (r_count < CW'(DEPTH)) & ~reset;
    assign w_disp_fire   = disp_valid_i & w_disp_ready & ~flush_i;

    assign disp_ready_o    = w_disp_ready;
    assign issue_valid_o   = w_issue_valid;
    assign issue_opcode_o  = w_issue_valid ? r_op[w_sel]  : '0;
    assign issue_dst_tag_o = w_issue_valid ? r_dst[w_sel] : '0;
    assign issue_src_tag_o = w_issue_valid ? r_src[w_sel] : '0;
    assign count_o         = r_count;

    always_comb begin
        w_rdy_wk   = '0;
        w_disp_rdy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                w_rdy_wk[i][s] = r_rdy[i][s] |
                    f_match(r_src[i][s*TAG_W +: TAG_W], wake_valid_i, wake_tag_i);
            end
        end
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            w_disp_rdy[s] = disp_src_rdy_i[s] |
                f_match(disp_src_tag_i[s*TAG_W +: TAG_W], wake_valid_i, wake_tag_i);
        end
    end

    // Order within one edge: wakeup, then collapse above the issued slot, then append.
    always_comb begin
        w_cnt_nxt = r_count + CW'(w_disp_fire) - CW'(w_issue_fire);
        w_wr      = r_count - CW'(w_issue_fire);
        w_vld_nxt = '0;
        w_op_nxt  = '0;
        w_dst_nxt = '0;
        w_src_nxt = '0;
        w_rdy_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            int unsigned j;
            j = i;
            if (w_issue_fire && (i >= 32'(w_sel)) && (i < DEPTH - 1)) j = i + 1;
            w_op_nxt[i]  = r_op[j];
            w_dst_nxt[i] = r_dst[j];
            w_src_nxt[i] = r_src[j];
            w_rdy_nxt[i] = w_rdy_wk[j];
            if (w_disp_fire && (CW'(i) == w_wr)) begin
                w_op_nxt[i]  = disp_opcode_i;
                w_dst_nxt[i] = disp_dst_tag_i;
                w_src_nxt[i] = disp_src_tag_i;
                w_rdy_nxt[i] = w_disp_rdy;
            end
            w_vld_nxt[i] = (CW'(i) < w_cnt_nxt);
            if (!w_vld_nxt[i]) w_rdy_nxt[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            r_count <= '0;
            r_valid <= '0;
            r_op    <= '0;
            r_dst   <= '0;
            r_src   <= '0;
            r_rdy   <= '0;
        end else begin
            r_count <= w_cnt_nxt;
            r_valid <= w_vld_nxt;
            r_op    <= w_op_nxt;
            r_dst   <= w_dst_nxt;
            r_src   <= w_src_nxt;
            r_rdy   <= w_rdy_nxt;
        end
    end

endmodule

// File: tb/tb_eu_ooo_issue_queue.sv
// Randomized bench for eu_ooo_issue_queue: a queue-based reference model feeds
// per-cycle status and issue-transaction scoreboards checked by a monitor.
module tb_eu_ooo_issue_queue;

    localparam int D  = 8;
    localparam int NS = 2;
    localparam int NW = 2;
    localparam int OW = 6;
    localparam int TW = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           disp_valid_i;
    logic           disp_ready_o;
    logic [OW-1:0]  disp_opcode_i;
    logic [TW-1:0]  disp_dst_tag_i;
    logic [NS*TW-1:0] disp_src_tag_i;
    logic [NS-1:0]  disp_src_rdy_i;
    logic [NW-1:0]  wake_valid_i;
    logic [NW*TW-1:0] wake_tag_i;
    logic           issue_valid_o;
    logic           issue_ready_i;
    logic [OW-1:0]  issue_opcode_o;
    logic [TW-1:0]  issue_dst_tag_o;
    logic [NS*TW-1:0] issue_src_tag_o;
    logic           flush_i;
    logic [3:0]     count_o;

    always #5 clk = ~clk;

    eu_ooo_issue_queue #(
        .LOG2_DEPTH(3), .NUM_SRC(NS), .NUM_WAKE(NW), .OPCODE_W(OW), .TAG_W(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_opcode_i(disp_opcode_i), .disp_dst_tag_i(disp_dst_tag_i),
        .disp_src_tag_i(disp_src_tag_i), .disp_src_rdy_i(disp_src_rdy_i),
        .wake_valid_i(wake_valid_i), .wake_tag_i(wake_tag_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_opcode_o(issue_opcode_o), .issue_dst_tag_o(issue_dst_tag_o),
        .issue_src_tag_o(issue_src_tag_o),
        .flush_i(flush_i), .count_o(count_o)
    );

    typedef struct packed {
        logic [OW-1:0]    op;
        logic [TW-1:0]    dst;
        logic [NS*TW-1:0] src;
        logic [NS-1:0]    rdy;
    } ent_t;

    typedef struct packed {
        logic       valid;
        logic       drdy;
        logic [3:0] cnt;
    } st_t;

    typedef struct packed {
        logic [OW-1:0]    op;
        logic [TW-1:0]    dst;
        logic [NS*TW-1:0] src;
    } iss_t;

    ent_t model[$];
    st_t  st_q[$];
    iss_t iss_q[$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit woken(input logic [TW-1:0] t);
        for (int w = 0; w < NW; w++)
            if (wake_valid_i[w] && (wake_tag_i[w*TW +: TW] == t)) return 1'b1;
        return 1'b0;
    endfunction

    // Model step: predict this cycle's outputs, then apply the edge.
    task automatic model_cycle();
        bit   exp_valid;
        bit   exp_drdy;
        int   sel;
        ent_t e;
        st_t  st;
        iss_t is;
        exp_valid = 1'b0;
        sel = 0;
        if (!reset && !flush_i) begin
            for (int k = 0; k < model.size(); k++) begin
                if (!exp_valid && (&model[k].rdy)) begin
                    exp_valid = 1'b1;
                    sel = k;
                end
            end
        end
        exp_drdy = !reset && (model.size() < D);
        st.valid = exp_valid;
        st.drdy  = exp_drdy;
        st.cnt   = 4'(model.size());
        st_q.push_back(st);
        if (exp_valid && issue_ready_i) begin
            is.op  = model[sel].op;
            is.dst = model[sel].dst;
            is.src = model[sel].src;
            iss_q.push_back(is);
        end
        if (reset || flush_i) begin
            model.delete();
        end else begin
            for (int k = 0; k < model.size(); k++)
                for (int s = 0; s < NS; s++)
                    if (woken(model[k].src[s*TW +: TW])) model[k].rdy[s] = 1'b1;
            if (exp_valid && issue_ready_i) model.delete(sel);
            if (disp_valid_i && exp_drdy) begin
                e.op  = disp_opcode_i;
                e.dst = disp_dst_tag_i;
                e.src = disp_src_tag_i;
                for (int s = 0; s < NS; s++)
                    e.rdy[s] = disp_src_rdy_i[s] | woken(disp_src_tag_i[s*TW +: TW]);
                model.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (st_q.size() > 0) begin
            st_t  st;
            iss_t is;
            st = st_q.pop_front();
            chk("issue_valid", 64'(issue_valid_o), 64'(st.valid));
            chk("disp_ready", 64'(disp_ready_o), 64'(st.drdy));
            chk("count", 64'(count_o), 64'(st.cnt));
            if (!st.valid)
                chk("idle_data_zero", 64'({issue_opcode_o, issue_dst_tag_o, issue_src_tag_o}), 64'(0));
            if (issue_valid_o && issue_ready_i) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", 64'(1), 64'(0));
                end else begin
                    is = iss_q.pop_front();
                    chk("issue_data", 64'({issue_opcode_o, issue_dst_tag_o, issue_src_tag_o}),
                        64'({is.op, is.dst, is.src}));
                end
            end
        end
    end

    // Knobs per phase (percent): dispatch, src ready, wake, issue_ready, flush, reset.
    int knobs [7][6] = '{
        '{90, 90, 10, 100, 0, 0},
        '{50, 30, 30,  80, 0, 0},
        '{95,  0,  0,   0, 0, 0},
        '{ 0,  0, 40, 100, 0, 0},
        '{70, 20, 20,  30, 0, 0},
        '{60, 40, 25,  60, 4, 2},
        '{80, 10, 50,  50, 0, 0}
    };

    function automatic bit pct(input int p);
        return ($urandom_range(0, 99) < p);
    endfunction

    initial begin
        reset          = 1'b1;
        disp_valid_i   = 1'b0;
        disp_opcode_i  = '0;
        disp_dst_tag_i = '0;
        disp_src_tag_i = '0;
        disp_src_rdy_i = '0;
        wake_valid_i   = '0;
        wake_tag_i     = '0;
        issue_ready_i  = 1'b0;
        flush_i        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int rep = 0; rep < 6; rep++) begin
            for (int ph = 0; ph < 7; ph++) begin
                for (int cyc = 0; cyc < 60; cyc++) begin
                    reset          = (rep == 0 && ph == 0 && cyc < 2) ? 1'b1 : pct(knobs[ph][5]);
                    disp_valid_i   = pct(knobs[ph][0]);
                    disp_opcode_i  = OW'($urandom);
                    disp_dst_tag_i = TW'($urandom);
                    for (int s = 0; s < NS; s++) begin
                        disp_src_tag_i[s*TW +: TW] = TW'($urandom_range(0, 15));
                        disp_src_rdy_i[s]          = pct(knobs[ph][1]);
                    end
                    for (int w = 0; w < NW; w++) begin
                        wake_valid_i[w]          = pct(knobs[ph][2]);
                        wake_tag_i[w*TW +: TW]   = TW'($urandom_range(0, 15));
                    end
                    issue_ready_i = pct(knobs[ph][3]);
                    flush_i       = pct(knobs[ph][4]);
                    model_cycle();
                    @(posedge clk);
                    #1;
                end
            end
        end
        reset         = 1'b0;
        flush_i       = 1'b0;
        disp_valid_i  = 1'b0;
        wake_valid_i  = '0;
        issue_ready_i = 1'b0;
        @(negedge clk);
        chk("status_drained", 64'(st_q.size()), 64'(0));
        chk("issues_drained", 64'(iss_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/eu_ooo_issue_queue.md
Name: eu_ooo_issue_queue

Overview:
- Parametrised successor to the per-EU in-order instruction queue.
- Holds up to 2**LOG2_DEPTH dispatched instructions and tracks per-source operand readiness via tag-broadcast wakeup ports.
- Issues the oldest ready entry to the ALU each cycle, out of program order.
- Sits between dispatch and the EU's ALU/cache pair; supports flush.

Parameters:
- LOG2_DEPTH, 3, log2 of entry count (DEPTH = 2**LOG2_DEPTH, minimum 2)
- NUM_SRC, 2, source operands per instruction
- NUM_WAKE, 2, wakeup broadcast channels
- OPCODE_W, 6, opcode width
- TAG_W, 6, operand/destination tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- disp_valid_i  in  1  dispatch request
- disp_ready_o  out  1  queue can accept a dispatch this cycle
- disp_opcode_i  in  OPCODE_W  instruction opcode
- disp_dst_tag_i  in  TAG_W  destination tag
- disp_src_tag_i  in  NUM_SRC*TAG_W  source tags; src s at bits [s*TAG_W +: TAG_W]
- disp_src_rdy_i  in  NUM_SRC  source already available at dispatch
- wake_valid_i  in  NUM_WAKE  wakeup channel valid
- wake_tag_i  in  NUM_WAKE*TAG_W  broadcast result tags
- issue_valid_o  out  1  a ready entry is presented
- issue_ready_i  in  1  ALU accepts the presented entry
- issue_opcode_o  out  OPCODE_W  issued opcode
- issue_dst_tag_o  out  TAG_W  issued destination tag
- issue_src_tag_o  out  NUM_SRC*TAG_W  issued source tags
- flush_i  in  1  discard all entries
- count_o  out  LOG2_DEPTH+1  occupied entries

Behaviour:
- Storage: collapsing array, slot 0 = oldest. Each slot holds valid, opcode, dst tag, NUM_SRC src tags and NUM_SRC rdy bits. Occupied slots are always 0..count-1, contiguous.
- Reset (clk edge with reset=1):
  - count=0, all valid and rdy bits cleared.
  - Outputs: disp_ready_o=0 while reset is high, issue_valid_o=0, count_o=0, issue_* data=0.
  - disp_ready_o=1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all contents identically.
- disp_ready_o = (count < DEPTH) and not reset. There is no bypass into a full queue, even when an issue fires in the same cycle.
- Dispatch fires when disp_valid_i & disp_ready_o & !flush_i.
  - The entry is written at slot count (or count-1 if an issue also fires that cycle).
  - rdy[s] = disp_src_rdy_i[s] OR any wake_valid_i[w] with wake_tag_i[w]==src_tag[s], i.e. same-cycle wakeup bypass at write.
- Wakeup: each cycle, for every valid slot and source, rdy is set if any valid wake channel matches src_tag. rdy bits are sticky until the entry leaves.
- A slot is ready when valid and all NUM_SRC rdy bits are 1. Readiness is based on registered rdy bits, so a wakeup in cycle N makes the entry issuable in cycle N+1.
- Select (combinational from state):
  - issue_valid_o=1 if any slot is ready and flush_i=0.
  - issue_* shows the lowest-index ready slot.
  - issue_* = 0 when issue_valid_o=0.
- Issue fires on issue_valid_o & issue_ready_i.
  - The selected slot k is removed at the clock edge; slots k+1..count-1 shift down by one, carrying their rdy bits plus any same-cycle wakeup.
  - If issue_valid_o=1 and issue_ready_i=0, the same entry must remain presented with identical data next cycle, unless an older entry became ready (selection is always the oldest ready).
- Count: next count = count + dispatch_fire - issue_fire. count_o is registered.
- Flush: at the clock edge with flush_i=1, all entries are invalidated and count=0.
  - A dispatch in the flush cycle is dropped.
  - issue_valid_o is forced to 0 during flush_i.
- Simultaneous dispatch + issue + wakeup are all applied in one edge in the order: wakeup, removal/collapse, append.
- Tags are compared for full equality; the queue performs no tag reservation.

Test Plan:
- Reset, then dispatch 3 entries with all rdy=1 and issue_ready_i=1 -> issued in dispatch order A,B,C on consecutive cycles; count_o returns to 0.
- Dispatch A (src tag 5 not ready) then B (ready) -> B issues first; wake tag 5 in cycle N -> A issue_valid_o=1 in N+1, count_o=0 afterwards.
- Fill DEPTH=8 entries, none ready -> disp_ready_o=0 with count_o=8; one wakeup readies slot 3 -> slot 3 issues, slots 4..7 collapse down, disp_ready_o=1 next cycle.
- Dispatch with src tag 9 while wake_tag_i[1]=9 is valid in the same cycle -> entry issuable the next cycle.
- Hold issue_ready_i=0 with a ready entry for 4 cycles -> issue_* stable; dispatch+issue in the same cycle at count=4 -> count stays 4.
- Assert flush_i with 5 entries plus a simultaneous dispatch -> issue_valid_o=0 that cycle, count_o=0 next cycle, dropped entry never issues; reset asserted with 6 entries -> all outputs are at reset values.
